// File: rtl/seven_seg_pkg.sv
// Shared constants for seven-segment encode/decode: active-low segment patterns
// (bits 6..0 = g..a), decimal-point bit position and anode helpers.
package seven_seg_pkg;

   localparam int         DP_BIT     = 7;
   localparam logic [3:0] ANODE_IDLE = 4'b1111;

   localparam logic [6:0] SEG_0 = 7'h40;
   localparam logic [6:0] SEG_1 = 7'h79;
   localparam logic [6:0] SEG_2 = 7'h24;
   localparam logic [6:0] SEG_3 = 7'h30;
   localparam logic [6:0] SEG_4 = 7'h19;
   localparam logic [6:0] SEG_5 = 7'h12;
   localparam logic [6:0] SEG_6 = 7'h02;
   localparam logic [6:0] SEG_7 = 7'h78;
   localparam logic [6:0] SEG_8 = 7'h00;
   localparam logic [6:0] SEG_9 = 7'h10;
   localparam logic [6:0] SEG_A = 7'h08;
   localparam logic [6:0] SEG_B = 7'h03;
   localparam logic [6:0] SEG_C = 7'h46;
   localparam logic [6:0] SEG_D = 7'h21;
   localparam logic [6:0] SEG_E = 7'h06;
   localparam logic [6:0] SEG_F = 7'h0E;

   function automatic logic anode_one_low(input logic [3:0] an);
      logic res;
      case (an)
         4'b1110, 4'b1101, 4'b1011, 4'b0111: res = 1'b1;
         default:                            res = 1'b0;
      endcase
      return res;
   endfunction

   function automatic logic [1:0] anode_index(input logic [3:0] an);
      logic [1:0] idx;
      case (an)
         4'b1110: idx = 2'd0;
         4'b1101: idx = 2'd1;
         4'b1011: idx = 2'd2;
         4'b0111: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/seven_seg_pattern_decoder.sv
// Combinational lookup from an active-low 7-segment pattern to its hex nibble.
module seven_seg_pattern_decoder
   import seven_seg_pkg::*;
(
   input  logic [6:0] pattern,
   output logic [3:0] nibble,
   output logic       match
);

   // Exact-match lookup; anything outside the 16 hex glyphs reports no match.
   always_comb begin
      nibble = 4'h0;
      match  = 1'b1;
      case (pattern)
         SEG_0:   nibble = 4'h0;
         SEG_1:   nibble = 4'h1;
         SEG_2:   nibble = 4'h2;
         SEG_3:   nibble = 4'h3;
         SEG_4:   nibble = 4'h4;
         SEG_5:   nibble = 4'h5;
         SEG_6:   nibble = 4'h6;
         SEG_7:   nibble = 4'h7;
         SEG_8:   nibble = 4'h8;
         SEG_9:   nibble = 4'h9;
         SEG_A:   nibble = 4'hA;
         SEG_B:   nibble = 4'hB;
         SEG_C:   nibble = 4'hC;
         SEG_D:   nibble = 4'hD;
         SEG_E:   nibble = 4'hE;
         SEG_F:   nibble = 4'hF;
         default: begin
            nibble = 4'h0;
            match  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/seven_seg_receiver.sv
// Recovers four hex digits from a multiplexed, active-low seven-segment display bus
// by sampling each digit once its pins have been stable for SETTLE cycles.
module seven_seg_receiver
   import seven_seg_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int SETTLE      = 4,
   parameter int TIMEOUT     = 65535
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  segments,
   input  logic [3:0]  anodes,
   output logic [15:0] digits,
   output logic [3:0]  decimal_points,
   output logic [3:0]  digit_valid,
   output logic        frame_done,
   output logic        anode_error,
   output logic        lost
);

   localparam int          TW           = $clog2(TIMEOUT + 1);
   localparam logic [7:0]  SETTLE_MAX   = 8'(SETTLE);
   localparam bit          EVERY_SAMPLE = (SETTLE_MAX == 8'd0);
   localparam logic [TW-1:0] TO_MAX     = TW'(TIMEOUT);
   localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] TO_ONE     = TW'(32'd1);
   localparam logic [11:0] SYNC_IDLE    = {ANODE_IDLE, 8'h00};

   logic [11:0]   sync_r [SYNC_STAGES];
   logic [11:0]   sample_s;
   logic [11:0]   prev_r;
   logic [7:0]    stable_r;
   logic [7:0]    stable_next_s;
   logic [3:0]    an_s;
   logic [7:0]    seg_s;
   logic          settled_s;
   logic          capture_s;
   logic          error_s;
   logic [1:0]    idx_s;
   logic [3:0]    cap_mask_s;
   logic [3:0]    dec_nibble_s;
   logic          dec_match_s;
   logic [TW-1:0] to_r;
   logic          timeout_hit_s;
   logic [3:0]    seen_r;
   logic [15:0]   digits_r;
   logic [3:0]    dp_r;
   logic [3:0]    valid_r;
   logic          frame_done_r;
   logic          anode_error_r;
   logic          lost_r;

   // Input synchronizer; anodes idle high so reset never looks like a selected digit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= SYNC_IDLE;
      end else begin
         sync_r[0] <= {anodes, segments};
         for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
      end
   end

   assign sample_s = sync_r[SYNC_STAGES-1];
   assign an_s     = sample_s[11:8];
   assign seg_s    = sample_s[7:0];

   // Next value of the saturating stability counter.
   always_comb begin
      stable_next_s = 8'd0;
      if (sample_s == prev_r) begin
         if (stable_r == SETTLE_MAX) stable_next_s = stable_r;
         else                        stable_next_s = stable_r + 8'd1;
      end else begin
         stable_next_s = 8'd0;
      end
   end

   // Previous sample and stability count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_r   <= SYNC_IDLE;
         stable_r <= 8'd0;
      end else begin
         prev_r   <= sample_s;
         stable_r <= stable_next_s;
      end
   end

   // Acting on the count's transition into SETTLE fires exactly once per stable period.
   assign settled_s     = (stable_next_s == SETTLE_MAX) && (EVERY_SAMPLE || (stable_r != SETTLE_MAX));
   assign capture_s     = settled_s && anode_one_low(an_s);
   assign error_s       = settled_s && !anode_one_low(an_s) && (an_s != ANODE_IDLE);
   assign idx_s         = anode_index(an_s);
   assign timeout_hit_s = !capture_s && (to_r == TO_LAST);

   // One-hot mask of the digit captured this cycle.
   always_comb begin
      cap_mask_s = 4'b0000;
      if (capture_s) cap_mask_s = 4'b0001 << idx_s;
      else           cap_mask_s = 4'b0000;
   end

   seven_seg_pattern_decoder u_decoder (
      .pattern (seg_s[6:0]),
      .nibble  (dec_nibble_s),
      .match   (dec_match_s)
   );

   // Digit, decimal-point, validity and lost registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         digits_r <= 16'h0000;
         dp_r     <= 4'b0000;
         valid_r  <= 4'b0000;
         lost_r   <= 1'b0;
      end else if (capture_s) begin
         dp_r[idx_s] <= ~seg_s[DP_BIT];
         lost_r      <= 1'b0;
         if (dec_match_s) begin
            digits_r[{idx_s, 2'b00} +: 4] <= dec_nibble_s;
            valid_r[idx_s]                <= 1'b1;
         end else begin
            valid_r[idx_s] <= 1'b0;
         end
      end else if (timeout_hit_s) begin
         lost_r  <= 1'b1;
         valid_r <= 4'b0000;
      end else begin
         lost_r <= lost_r;
      end
   end

   // Frame tracking: a full mask pulses frame_done and restarts with this cycle's capture.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seen_r        <= 4'b0000;
         frame_done_r  <= 1'b0;
         anode_error_r <= 1'b0;
      end else begin
         anode_error_r <= error_s;
         if (seen_r == 4'b1111) begin
            frame_done_r <= 1'b1;
            seen_r       <= cap_mask_s;
         end else if (timeout_hit_s) begin
            frame_done_r <= 1'b0;
            seen_r       <= 4'b0000;
         end else begin
            frame_done_r <= 1'b0;
            seen_r       <= seen_r | cap_mask_s;
         end
      end
   end

   // Cycles since the last capture, saturating at TIMEOUT.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         to_r <= {TW{1'b0}};
      end else if (capture_s) begin
         to_r <= {TW{1'b0}};
      end else if (to_r != TO_MAX) begin
         to_r <= to_r + TO_ONE;
      end else begin
         to_r <= to_r;
      end
   end

   assign digits         = digits_r;
   assign decimal_points = dp_r;
   assign digit_valid    = valid_r;
   assign frame_done     = frame_done_r;
   assign anode_error    = anode_error_r;
   assign lost           = lost_r;

endmodule

// File: tb/tb_seven_seg_receiver.sv
// Scoreboard bench: each held pin pattern pushes the expected display state for the
// cycle its capture should land; a negedge monitor pops and compares on that cycle.
module tb_seven_seg_receiver;

   localparam int SYNC = 2;
   localparam int SET  = 4;
   localparam int TMO  = 100;
   localparam int LAT  = SYNC + SET + 1;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  segments = 8'h00;
   logic [3:0]  anodes = 4'hF;
   logic [15:0] digits;
   logic [3:0]  decimal_points;
   logic [3:0]  digit_valid;
   logic        frame_done;
   logic        anode_error;
   logic        lost;

   seven_seg_receiver #(.SYNC_STAGES(SYNC), .SETTLE(SET), .TIMEOUT(TMO)) dut (
      .clk            (clk),
      .reset          (reset),
      .segments       (segments),
      .anodes         (anodes),
      .digits         (digits),
      .decimal_points (decimal_points),
      .digit_valid    (digit_valid),
      .frame_done     (frame_done),
      .anode_error    (anode_error),
      .lost           (lost)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          due;
      logic [15:0] digits;
      logic [3:0]  dp;
      logic [3:0]  valid;
      logic        lost;
      int          fd;
      int          err;
   } exp_t;

   exp_t sb_q[$];
   exp_t e;

   int n_checks = 0;
   int n_errors = 0;
   int fd_seen  = 0;
   int err_seen = 0;

   logic [15:0] m_digits = 16'h0;
   logic [3:0]  m_dp = 4'h0, m_valid = 4'h0, m_seen = 4'h0;
   logic        m_lost = 1'b0;
   int          m_last = 0, m_fd = 0, m_err = 0;

   task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, act, exp);
      end
   endtask

   function automatic logic [6:0] hex_low(input logic [3:0] n);
      logic [6:0] hi;
      case (n)
         4'h0: hi = 7'h3F;  4'h1: hi = 7'h06;  4'h2: hi = 7'h5B;  4'h3: hi = 7'h4F;
         4'h4: hi = 7'h66;  4'h5: hi = 7'h6D;  4'h6: hi = 7'h7D;  4'h7: hi = 7'h07;
         4'h8: hi = 7'h7F;  4'h9: hi = 7'h6F;  4'hA: hi = 7'h77;  4'hB: hi = 7'h7C;
         4'hC: hi = 7'h39;  4'hD: hi = 7'h5E;  4'hE: hi = 7'h79;  4'hF: hi = 7'h71;
         default: hi = 7'h00;
      endcase
      return ~hi;
   endfunction

   function automatic logic [7:0] seg_byte(input logic [3:0] n, input logic dp_lit);
      return {~dp_lit, hex_low(n)};
   endfunction

   function automatic logic [3:0] an_sel(input int idx);
      logic [3:0] one = 4'b0001;
      return ~(one << idx);
   endfunction

   task automatic push_rec(input int due);
      exp_t r;
      r.due = due; r.digits = m_digits; r.dp = m_dp; r.valid = m_valid;
      r.lost = m_lost; r.fd = m_fd; r.err = m_err;
      sb_q.push_back(r);
   endtask

   task automatic advance(input int c);
      if (!m_lost && (c - m_last >= TMO)) begin
         m_lost = 1'b1; m_valid = 4'h0; m_seen = 4'h0;
      end
   endtask

   task automatic push_check(input int c);
      advance(c);
      push_rec(c);
   endtask

   task automatic model_capture(input int d, input logic [3:0] an, input logic [7:0] seg);
      int idx = 0;
      for (int k = 0; k < 4; k++) if (an[k] == 1'b0) idx = k;
      m_dp[idx]    = ~seg[7];
      m_valid[idx] = 1'b0;
      for (int k = 0; k < 16; k++) begin
         if (seg[6:0] == hex_low(4'(k))) begin
            m_digits[idx*4 +: 4] = 4'(k);
            m_valid[idx]         = 1'b1;
         end
      end
      m_seen[idx] = 1'b1;
      m_lost = 1'b0;
      m_last = d;
      push_rec(d);
      if (m_seen == 4'hF) begin
         m_fd++;
         m_seen = 4'h0;
      end
   endtask

   task automatic hold(input logic [3:0] an, input logic [7:0] seg, input int n);
      int st;
      @(negedge clk);
      anodes = an; segments = seg; st = cyc;
      if (n >= SET + 1 && $countones(~an) == 1) begin
         push_check(st + LAT - 1);
         model_capture(st + LAT, an, seg);
      end else begin
         advance(st + LAT);
         if (n >= SET + 1 && $countones(~an) > 1) m_err++;
         push_rec(st + LAT);
      end
      repeat (n - 1) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      reset = 1'b1; anodes = 4'hF; segments = 8'h00;
      sb_q.delete();
      m_digits = 16'h0; m_dp = 4'h0; m_valid = 4'h0; m_seen = 4'h0; m_lost = 1'b0;
      #1;
      check_value("rst_digits", 32'(digits), 32'h0);
      check_value("rst_dp", 32'(decimal_points), 32'h0);
      check_value("rst_valid", 32'(digit_valid), 32'h0);
      check_value("rst_frame_done", 32'(frame_done), 32'h0);
      check_value("rst_anode_error", 32'(anode_error), 32'h0);
      check_value("rst_lost", 32'(lost), 32'h0);
      @(negedge clk);
      #2;
      reset = 1'b0;
      m_last = cyc;
   endtask

   // Scoreboard monitor: count pulses, then compare any record due this cycle.
   always @(negedge clk) begin
      if (!reset) begin
         if (frame_done === 1'b1) fd_seen++;
         if (anode_error === 1'b1) err_seen++;
         while (sb_q.size() > 0 && sb_q[0].due < cyc) begin
            check_value("sched", 32'(cyc), 32'(sb_q[0].due));
            void'(sb_q.pop_front());
         end
         if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            e = sb_q.pop_front();
            check_value("digits", 32'(digits), 32'(e.digits));
            check_value("dp", 32'(decimal_points), 32'(e.dp));
            check_value("valid", 32'(digit_valid), 32'(e.valid));
            check_value("lost", 32'(lost), 32'(e.lost));
            check_value("frame_cnt", 32'(fd_seen), 32'(e.fd));
            check_value("err_cnt", 32'(err_seen), 32'(e.err));
         end
      end
   end

   initial begin
      do_reset();
      // single digit 2 on digit 0, dp off
      hold(4'b1110, 8'b10100100, 10);
      // scan A5C3 with dp on digit 2
      hold(an_sel(0), seg_byte(4'h3, 1'b0), 6);
      hold(an_sel(1), seg_byte(4'hC, 1'b0), 6);
      hold(an_sel(2), seg_byte(4'h5, 1'b1), 6);
      hold(an_sel(3), seg_byte(4'hA, 1'b0), 6);
      hold(4'hF, 8'h00, 8);
      // two anodes low, then blanking
      hold(4'b1100, seg_byte(4'h8, 1'b0), 8);
      hold(4'hF, 8'h00, 8);
      // too short to settle
      hold(an_sel(3), seg_byte(4'h1, 1'b0), 3);
      hold(4'hF, 8'h00, 6);
      // all-off pattern on digit 1
      hold(an_sel(1), 8'hFF, 6);
      for (int k = 0; k < 16; k++) hold(an_sel(k % 4), seg_byte(4'(k), k[0]), 5 + (k % 3));
      // timeout after idle, then recovery
      hold(4'hF, 8'h00, 1);
      push_check(m_last + TMO - 1);
      push_check(m_last + TMO);
      repeat (TMO + 20) @(negedge clk);
      hold(an_sel(2), seg_byte(4'h7, 1'b0), 6);
      // reset mid-scan with three digits already seen
      hold(an_sel(0), seg_byte(4'h1, 1'b0), 6);
      hold(an_sel(1), seg_byte(4'h2, 1'b0), 6);
      hold(an_sel(2), seg_byte(4'h3, 1'b1), 6);
      hold(an_sel(3), seg_byte(4'h4, 1'b0), 4);
      do_reset();
      hold(an_sel(3), seg_byte(4'h9, 1'b0), 6);
      hold(an_sel(2), seg_byte(4'hE, 1'b0), 6);
      hold(an_sel(1), seg_byte(4'hD, 1'b1), 6);
      hold(an_sel(0), seg_byte(4'hB, 1'b0), 6);
      hold(4'hF, 8'h00, 10);
      for (int i = 0; i < 200 && sb_q.size() > 0; i++) @(negedge clk);
      check_value("drain", 32'(sb_q.size()), 32'd0);
      repeat (3) @(negedge clk);
      check_value("frame_total", 32'(fd_seen), 32'(m_fd));
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/seven_seg_receiver.md
SEVEN_SEG_RECEIVER -- requirements
Module: seven_seg_receiver

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: input synchronizer depth, range 1..3.
REQ-002 SHALL have parameter SETTLE, default 4: consecutive unchanged synchronized samples required before capture; 0 means capture on every valid sample.
REQ-003 SHALL have parameter TIMEOUT, default 65535: cycles without a capture before the display is declared lost.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port segments, input, 8: bit 7 is the decimal point, bits 6..0 are segments g..a; active-low (0 = lit).
REQ-007 SHALL have port anodes, input, 4: digit selects, active-low; bit i selects digit i.
REQ-008 SHALL have port digits, output, 16: the recovered hex digits; digit i is on bits 4i+3..4i.
REQ-009 SHALL have port decimal_points, output, 4: the recovered decimal point per digit, 1 = lit.
REQ-010 SHALL have port digit_valid, output, 4: 1 = the last capture for that digit decoded to a legal hex pattern.
REQ-011 SHALL have port frame_done, output, 1: one-cycle pulse when all four digits have been captured since the last pulse.
REQ-012 SHALL have port anode_error, output, 1: one-cycle pulse on a stable sample with more than one anode low.
REQ-013 SHALL have port lost, output, 1: level, 1 = no capture for TIMEOUT cycles.

Function
REQ-014 SHALL pass segments and anodes through a SYNC_STAGES-deep flop chain before any use.
REQ-015 SHALL keep an 8-bit stable counter, saturating at SETTLE, that increments when the synchronized {anodes, segments} equals the previous cycle's value and clears to 0 on any change.
REQ-016 SHALL capture on a cycle when the stable counter equals SETTLE and exactly one anode bit is low, at most once per stable period.
REQ-017 SHALL NOT capture, and SHALL NOT flag an error, when all anodes are high (blanking).
REQ-018 SHALL NOT capture on a stable sample with two or more anodes low, and SHALL pulse anode_error once per such stable period.
REQ-019 On capture of digit i, SHALL load decimal_points[i] = ~segments[7].
REQ-020 On capture of digit i, SHALL decode segments[6:0] using the standard hex 0-F table (b and d in lowercase form); a match loads the nibble and sets digit_valid[i].
REQ-021 On capture of digit i with a non-matching pattern, including all-off, SHALL clear digit_valid[i] and leave the nibble unchanged.
REQ-022 SHALL update outputs SYNC_STAGES+SETTLE+1 clock edges after the pins settle.
REQ-023 SHALL keep a 4-bit seen mask that sets bit i on capture of digit i.
REQ-024 When the seen mask becomes 4'b1111, SHALL pulse frame_done on the next cycle and clear the mask in the same cycle; a capture in that cycle SHALL set its bit in the cleared mask.
REQ-025 SHALL keep a timeout counter that clears on each capture and saturates at TIMEOUT.
REQ-026 On reaching TIMEOUT, SHALL set lost and clear digit_valid and the seen mask; lost SHALL clear on the next capture.

Reset
REQ-027 While reset is high, SHALL hold digits=0, decimal_points=0, digit_valid=0, frame_done=0, anode_error=0, lost=0, all counters, the mask and the synchronizer at 0, and the synchronizer anode bits at 1.
REQ-028 A reset asserted mid-capture SHALL discard the partial frame; after reset release, the first capture SHALL require a full SETTLE period.

Structure
REQ-029 Package seven_seg_pkg SHALL hold the 16 segment pattern constants, the DP bit index and the anode-idle constant 4'b1111, shared with the display decoder.
REQ-030 The pattern-to-nibble lookup SHALL be one combinational sub-module, seven_seg_pattern_decoder, with outputs nibble and match.

Verification
REQ-031 SETTLE=4: drive anodes=4'b1110, segments=8'b1_0100100 for 10 cycles -> digits[3:0]=2, digit_valid[0]=1, decimal_points[0]=0, after 7 edges.
REQ-032 Scan 4'hA5C3 with DP lit on digit 2, each digit held 6 cycles -> frame_done pulses once, digits=16'hA5C3, decimal_points=4'b0100, digit_valid=4'b1111.
REQ-033 Stable anodes=4'b1100 -> anode_error pulses once, no output change; anodes=4'b1111 -> no capture, no error.
REQ-034 Capture pattern 7'b1111111 on digit 1 -> digit_valid[1]=0, digits[7:4] retains its prior value.
REQ-035 TIMEOUT=100, inputs idle after a frame -> lost=1 and digit_valid=0 at cycle 100; the next capture clears lost.
REQ-036 Assert reset mid-scan for 1 cycle -> all outputs 0, no frame_done until four fresh captures occur.
